// File: rtl/ysyx_imem_resp.sv
// Instruction-memory responder: word array with a backdoor byte-strobed write port
// and a fixed-latency IDLE/WAIT/RESP read FSM that flags bad addresses with rerr.
module ysyx_imem_resp #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rerr,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  output logic              busy
);

  localparam int              DEPTH  = 1 << DEPTH_LOG2;
  localparam int              CNT_W  = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam bit              LAT1   = (LATENCY == 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [DATA_W-1:0]     r_mem [DEPTH];
  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_rvalid;
  logic                  r_rerr;
  logic [DATA_W-1:0]     r_rdata;

  logic [ADDR_W-1:0]     w_woff;
  logic [ADDR_W-1:0]     w_roff;
  logic [ADDR_W-1:0]     w_raddr;
  logic                  w_wok;
  logic                  w_rok;
  logic [DEPTH_LOG2-1:0] w_widx;
  logic [DEPTH_LOG2-1:0] w_ridx;
  logic                  w_hit;
  logic                  w_enter_resp;
  logic [DATA_W-1:0]     w_fwd;

  // The subtraction is unsigned at ADDR_W bits, so addresses below BASE are
  // rejected explicitly rather than relying on wrap-around.
  assign w_woff  = waddr - BASE_A;
  assign w_wok   = (waddr >= BASE_A) && ((w_woff >> (DEPTH_LOG2 + 2)) == '0) && (waddr[1:0] == 2'b00);
  assign w_widx  = w_woff[DEPTH_LOG2+1:2];

  // With LATENCY=1 the response is built straight from the incoming address.
  assign w_raddr = (r_state == IDLE) ? araddr : r_addr;
  assign w_roff  = w_raddr - BASE_A;
  assign w_rok   = (w_raddr >= BASE_A) && ((w_roff >> (DEPTH_LOG2 + 2)) == '0) && (w_raddr[1:0] == 2'b00);
  assign w_ridx  = w_roff[DEPTH_LOG2+1:2];

  assign w_enter_resp = !rst && (((r_state == IDLE) && arvalid && LAT1) ||
                                 ((r_state == WAIT) && (r_cnt == CNT_W'(1))));
  assign w_hit = wen && w_wok && (w_widx == w_ridx);

  // A write landing on the same edge that enters RESP must be seen by the read.
  always_comb begin
    w_fwd = r_mem[w_ridx];
    if (w_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) w_fwd[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  // Array contents survive reset and loader writes commit in any state.
  always_ff @(posedge clk) begin
    if (wen && w_wok) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) r_mem[w_widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
      r_rdata  <= '0;
      if (w_enter_resp) begin
        r_rvalid <= 1'b1;
        r_rerr   <= !w_rok;
        r_rdata  <= w_rok ? w_fwd : '0;
      end
      case (r_state)
        IDLE: begin
          if (arvalid) begin
            r_addr  <= araddr;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_state <= LAT1 ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rvalid = r_rvalid;
  assign rerr   = r_rerr;
  assign rdata  = r_rdata;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_ysyx_imem_resp.sv
// Directed bench for ysyx_imem_resp: three instances (LATENCY 2, 1, 4) share
// the stimulus; each scenario task checks its own hand-computed expectations.
module tb_ysyx_imem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        wen;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic [31:0] rdata2, rdata1, rdata4;
  logic        rvalid2, rvalid1, rvalid4;
  logic        rerr2, rerr1, rerr4;
  logic        busy2, busy1, busy4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_imem_resp #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid),
    .rdata(rdata2), .rvalid(rvalid2), .rerr(rerr2),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .busy(busy2)
  );

  ysyx_imem_resp #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid),
    .rdata(rdata1), .rvalid(rvalid1), .rerr(rerr1),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .busy(busy1)
  );

  ysyx_imem_resp #(.LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid),
    .rdata(rdata4), .rvalid(rvalid4), .rerr(rerr4),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .busy(busy4)
  );

  // Outputs are read 1 time unit after the rising edge; inputs set there are
  // sampled at the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wen = 1'b1; waddr = a; wdata = d; wstrb = s;
    tick();
    wen = 1'b0; wstrb = 4'h0;
  endtask

  // Issues one request on the LATENCY=2 instance and reports latency/data/error.
  task automatic read2(input logic [31:0] a, output int lat, output logic [31:0] d, output logic e);
    lat = -1; d = 32'hx; e = 1'bx;
    araddr = a; arvalid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rvalid2) begin
        lat = k; d = rdata2; e = rerr2;
        break;
      end
    end
    arvalid = 1'b0;
    tick();
    do_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; arvalid = 1'b1; araddr = 32'h8000_0000;
    tick(); tick();
    total++; if (rvalid2 !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", rvalid2); end
    total++; if (rerr2 !== 1'b0) begin bad++; $display("FAIL reset_rerr got=%b want=0", rerr2); end
    total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata2); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0 (arvalid during rst)", busy2); end
    rst = 1'b0; arvalid = 1'b0;
    tick();
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy2); end
  endtask

  task automatic test_basic();
    mem_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    araddr = 32'h8000_0010; arvalid = 1'b1;
    tick();
    total++; if ({busy2, rvalid2} !== 2'b10) begin bad++; $display("FAIL basic_t1 busy,rvalid got=%b want=10", {busy2, rvalid2}); end
    tick();
    total++; if ({busy2, rvalid2, rerr2} !== 3'b110) begin bad++; $display("FAIL basic_t2 busy,rvalid,rerr got=%b want=110", {busy2, rvalid2, rerr2}); end
    total++; if (rdata2 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_rdata got=%h want=deadbeef", rdata2); end
    arvalid = 1'b0;
    tick();
    total++; if ({busy2, rvalid2} !== 2'b00) begin bad++; $display("FAIL basic_t3 busy,rvalid got=%b want=00", {busy2, rvalid2}); end
    total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL basic_t3_rdata got=%h want=0", rdata2); end
    do_reset();
  endtask

  task automatic test_errors();
    int          lat;
    logic [31:0] d;
    logic        e;
    logic [31:0] addrs [4] = '{32'h7FFF_FFFC, 32'h8000_0002, 32'h8000_1000, 32'h8000_0FFC};
    logic        errs  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    mem_write(32'h8000_0FFC, 32'h0BAD_F00D, 4'hF);
    mem_write(32'h8000_0000, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 4; i++) begin
      read2(addrs[i], lat, d, e);
      total++; if (lat !== 2) begin bad++; $display("FAIL err_lat[%0d] got=%0d want=2", i, lat); end
      total++; if (e !== errs[i]) begin bad++; $display("FAIL err_flag[%0d] got=%b want=%b", i, e, errs[i]); end
      total++; if (d !== (errs[i] ? 32'h0 : 32'h0BAD_F00D)) begin bad++; $display("FAIL err_data[%0d] got=%h want=%h", i, d, errs[i] ? 32'h0 : 32'h0BAD_F00D); end
    end
  endtask

  task automatic test_strobe();
    int          lat;
    logic [31:0] d;
    logic        e;
    mem_write(32'h8000_0020, 32'h1122_3344, 4'hF);
    mem_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101);
    read2(32'h8000_0020, lat, d, e);
    total++; if (d !== 32'h11BB_33DD) begin bad++; $display("FAIL strobe_merge got=%h want=11bb33dd", d); end
    mem_write(32'h8000_0020, 32'hFFFF_FFFF, 4'h0);
    mem_write(32'h8000_0022, 32'hFFFF_FFFF, 4'hF);
    mem_write(32'h8000_1020, 32'hFFFF_FFFF, 4'hF);
    mem_write(32'h7FFF_FFE0, 32'hFFFF_FFFF, 4'hF);
    read2(32'h8000_0020, lat, d, e);
    total++; if (d !== 32'h11BB_33DD) begin bad++; $display("FAIL strobe_dropped_writes got=%h want=11bb33dd", d); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL strobe_rerr got=%b want=0", e); end
  endtask

  task automatic test_back_to_back();
    araddr = 32'h8000_0010; arvalid = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      total++; if (rvalid1 !== ((k % 2) == 1)) begin bad++; $display("FAIL b2b_lat1 cycle=%0d got=%b want=%b", k, rvalid1, (k % 2) == 1); end
      total++; if (rvalid4 !== ((k % 5) == 4)) begin bad++; $display("FAIL b2b_lat4 cycle=%0d got=%b want=%b", k, rvalid4, (k % 5) == 4); end
      if ((k % 2) == 1) begin
        total++; if (rdata1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL b2b_lat1_data cycle=%0d got=%h want=deadbeef", k, rdata1); end
      end
    end
    do_reset();
  endtask

  task automatic test_write_hazard();
    int          lat;
    logic [31:0] d;
    logic        e;
    mem_write(32'h8000_0030, 32'h0000_1111, 4'hF);
    araddr = 32'h8000_0030; arvalid = 1'b1;
    tick(); tick();
    arvalid = 1'b0;
    total++; if (rvalid2 !== 1'b1) begin bad++; $display("FAIL hazard_resp_rvalid got=%b want=1", rvalid2); end
    total++; if (rdata2 !== 32'h0000_1111) begin bad++; $display("FAIL hazard_same_cycle got=%h want=00001111", rdata2); end
    wen = 1'b1; waddr = 32'h8000_0030; wdata = 32'h5; wstrb = 4'hF;
    tick();
    wen = 1'b0;
    do_reset();
    read2(32'h8000_0030, lat, d, e);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL hazard_next_read got=%h want=00000005", d); end
    mem_write(32'h8000_0030, 32'h0000_1111, 4'hF);
    araddr = 32'h8000_0030; arvalid = 1'b1;
    tick();
    wen = 1'b1; waddr = 32'h8000_0030; wdata = 32'h5; wstrb = 4'hF;
    tick();
    wen = 1'b0; arvalid = 1'b0;
    total++; if (rdata2 !== 32'h5) begin bad++; $display("FAIL hazard_early_write got=%h want=00000005", rdata2); end
    tick();
    do_reset();
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [31:0] d;
    logic        e;
    araddr = 32'h8000_0010; arvalid = 1'b1;
    tick();
    rst = 1'b1; arvalid = 1'b0;
    wen = 1'b1; waddr = 32'h8000_0040; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    tick();
    rst = 1'b0; wen = 1'b0;
    total++; if ({busy2, rvalid2} !== 2'b00) begin bad++; $display("FAIL midrst_abort busy,rvalid got=%b want=00", {busy2, rvalid2}); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (rvalid2 !== 1'b0) begin bad++; $display("FAIL midrst_no_resp cycle=%0d got=%b want=0", k, rvalid2); end
    end
    read2(32'h8000_0010, lat, d, e);
    total++; if (lat !== 2 || d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL midrst_followup lat=%0d data=%h want lat=2 data=deadbeef", lat, d); end
    read2(32'h8000_0040, lat, d, e);
    total++; if (d !== 32'hCAFE_F00D) begin bad++; $display("FAIL midrst_write_in_reset got=%h want=cafef00d", d); end
  endtask

  initial begin
    rst = 1'b1; arvalid = 1'b0; araddr = '0;
    wen = 1'b0; waddr = '0; wdata = '0; wstrb = 4'h0;
    test_reset();
    test_basic();
    test_errors();
    test_strobe();
    test_back_to_back();
    test_write_hazard();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
